// File: rtl/sci_master.sv
// SCI initiator: turns single-word register read/write requests into the
// serial SCI frame (per-slave CSN, serial REQ, slave ACK and serial RESP).
// One transaction at a time; responses are reported with a one-cycle pulse.
module sci_master #(
    parameter int NUM_SLAVES     = 8,
    parameter int SEL_WIDTH      = 3,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WNR,
    input  logic [SEL_WIDTH-1:0]  REQ_SEL,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RESP_VALID,
    output logic [DATA_WIDTH-1:0] RESP_RDATA,
    output logic                  RESP_ERR,
    output logic [NUM_SLAVES-1:0] SCI_CSN,
    output logic                  SCI_REQ,
    input  logic                  SCI_RESP,
    input  logic                  SCI_ACK
);

    localparam int MAX_W   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FRAME_W = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WAIT_ACK, S_RDATA, S_DONE
    } state_t;

    state_t                state_q;
    logic                  wnr_q;
    logic [FRAME_W-1:0]    frame_q;     // {addr, wdata}, shifted out MSB first
    logic [CNT_W-1:0]      cnt_q;
    logic [IDLE_W-1:0]     idle_q;
    logic [DATA_WIDTH-1:0] rshift_q;
    logic [NUM_SLAVES-1:0] csn_q;
    logic                  sci_req_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    logic [NUM_SLAVES-1:0] csn_d;
    logic                  sel_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  done_d;
    logic                  err_d;
    logic [DATA_WIDTH-1:0] data_d;

    assign REQ_READY  = ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;
    assign RESP_ERR   = resp_err_q;
    assign SCI_CSN    = csn_q;
    assign SCI_REQ    = sci_req_q;

    assign accept     = REQ_VALID && ready_q;
    assign rdata_next = DATA_WIDTH'({rshift_q, SCI_RESP});

    // Decode the requested slave index into a one-hot active-low chip select.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        csn_d  = '1;
        sel_ok = (int'(REQ_SEL) < NUM_SLAVES);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (REQ_SEL == SEL_WIDTH'(i)) csn_d[i] = 1'b0;
        end
    end

    // Decide whether this edge completes the transaction, and with what result.
    always_comb begin
        done_d = 1'b0;
        err_d  = 1'b0;
        data_d = '0;
        case (state_q)
            S_IDLE: begin
                if (accept && !sel_ok) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (SCI_ACK) begin
                    if (wnr_q) begin
                        done_d = 1'b1;
                    end else if (DATA_WIDTH == 1) begin
                        done_d = 1'b1;
                        data_d = rdata_next;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (SCI_ACK) begin
                    if (cnt_q == DATA_LAST) begin
                        done_d = 1'b1;
                        data_d = rdata_next;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    // Partial read data is dropped on timeout.
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer with registered bus and response outputs; reset is synchronous.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees pre-edge values regardless of statement order.
        if (!RSTN) begin
            state_q      <= S_IDLE;
            wnr_q        <= 1'b0;
            frame_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            rshift_q     <= '0;
            csn_q        <= '1;
            sci_req_q    <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (done_d) begin
                state_q      <= S_DONE;
                csn_q        <= '1;
                sci_req_q    <= 1'b0;
                ready_q      <= 1'b0;
                resp_valid_q <= 1'b1;
                resp_err_q   <= err_d;
                resp_rdata_q <= data_d;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q   <= S_CMD;
                            ready_q   <= 1'b0;
                            wnr_q     <= REQ_WNR;
                            frame_q   <= {REQ_ADDR, REQ_WDATA};
                            csn_q     <= csn_d;
                            sci_req_q <= REQ_WNR;
                        end
                    end
                    S_CMD: begin
                        state_q   <= S_ADDR;
                        cnt_q     <= '0;
                        sci_req_q <= frame_q[FRAME_W-1];
                        frame_q   <= frame_q << 1;
                    end
                    S_ADDR: begin
                        if (cnt_q == ADDR_LAST && !wnr_q) begin
                            state_q   <= S_WAIT_ACK;
                            idle_q    <= '0;
                            sci_req_q <= 1'b0;
                        end else begin
                            if (cnt_q == ADDR_LAST) begin
                                state_q <= S_WDATA;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q   <= cnt_q + CNT_W'(1);
                            end
                            sci_req_q <= frame_q[FRAME_W-1];
                            frame_q   <= frame_q << 1;
                        end
                    end
                    S_WDATA: begin
                        if (cnt_q == DATA_LAST) begin
                            state_q   <= S_WAIT_ACK;
                            idle_q    <= '0;
                            sci_req_q <= 1'b0;
                        end else begin
                            cnt_q     <= cnt_q + CNT_W'(1);
                            sci_req_q <= frame_q[FRAME_W-1];
                            frame_q   <= frame_q << 1;
                        end
                    end
                    S_WAIT_ACK: begin
                        // Write ACK and timeout are handled by the done path.
                        if (SCI_ACK) begin
                            state_q  <= S_RDATA;
                            rshift_q <= rdata_next;
                            cnt_q    <= CNT_W'(1);
                            idle_q   <= '0;
                        end else begin
                            idle_q   <= idle_q + IDLE_W'(1);
                        end
                    end
                    S_RDATA: begin
                        if (SCI_ACK) begin
                            rshift_q <= rdata_next;
                            cnt_q    <= cnt_q + CNT_W'(1);
                            idle_q   <= '0;
                        end else begin
                            idle_q   <= idle_q + IDLE_W'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sci_master.sv
// Directed bench for sci_master: frame bits are checked cycle by cycle and
// completed responses are matched against a scoreboard queue of expectations.
module tb_sci_master;

    logic       CLK;
    logic       RSTN;
    logic       REQ_VALID;
    logic       REQ_VALID6;
    logic       REQ_WNR;
    logic [2:0] REQ_SEL;
    logic [3:0] REQ_ADDR;
    logic [7:0] REQ_WDATA;
    logic       SCI_RESP;
    logic       SCI_ACK;

    logic       REQ_READY;
    logic       RESP_VALID;
    logic [7:0] RESP_RDATA;
    logic       RESP_ERR;
    logic [7:0] SCI_CSN;
    logic       SCI_REQ;

    logic       REQ_READY6;
    logic       RESP_VALID6;
    logic [7:0] RESP_RDATA6;
    logic       RESP_ERR6;
    logic [5:0] SCI_CSN6;
    logic       SCI_REQ6;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    sci_master u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WNR(REQ_WNR),
        .REQ_SEL(REQ_SEL), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
        .SCI_CSN(SCI_CSN), .SCI_REQ(SCI_REQ), .SCI_RESP(SCI_RESP), .SCI_ACK(SCI_ACK)
    );

    // Six-slave instance so that index 7 is out of range.
    sci_master #(.NUM_SLAVES(6)) u_dut6 (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID6), .REQ_READY(REQ_READY6), .REQ_WNR(REQ_WNR),
        .REQ_SEL(REQ_SEL), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID6), .RESP_RDATA(RESP_RDATA6), .RESP_ERR(RESP_ERR6),
        .SCI_CSN(SCI_CSN6), .SCI_REQ(SCI_REQ6), .SCI_RESP(1'b0), .SCI_ACK(1'b0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] frame_bits(input logic wnr, input logic [3:0] addr,
                                               input logic [7:0] data);
        return wnr ? {3'b000, wnr, addr, data} : {11'b0, wnr, addr};
    endfunction

    // Drive one request on the main instance; it is accepted at the next edge.
    task automatic issue(input logic wnr, input logic [2:0] sel, input logic [3:0] addr,
                         input logic [7:0] wdata, input logic exp_err, input logic [7:0] exp_rdata);
        exp_t e;
        REQ_WNR   = wnr;
        REQ_SEL   = sel;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_VALID = 1'b1;
        check("ready_before_accept", 32'(REQ_READY), 32'd1);
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb.push_back(e);
        step();
        REQ_VALID = 1'b0;
    endtask

    // Check n frame bits (MSB first) starting at the first frame cycle.
    task automatic expect_frame(input logic [7:0] csn_exp, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            check("frame_csn", 32'(SCI_CSN), 32'(csn_exp));
            check("frame_req", 32'(SCI_REQ), 32'(bits[i]));
            check("frame_ready", 32'(REQ_READY), 32'd0);
            step();
        end
        check("frame_end_req", 32'(SCI_REQ), 32'd0);
        check("frame_end_csn", 32'(SCI_CSN), 32'(csn_exp));
    endtask

    // Slave returns a read word MSB first, with an optional ACK gap before bit gap_at.
    task automatic send_read(input logic [7:0] data, input int gap_at, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                SCI_ACK  = 1'b0;
                SCI_RESP = 1'b1;
                repeat (gap_len) step();
            end
            SCI_ACK  = 1'b1;
            SCI_RESP = data[7 - i];
            step();
        end
        SCI_ACK  = 1'b0;
        SCI_RESP = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_valid"}, 32'(RESP_VALID), 32'd1);
        check({tag, "_csn"}, 32'(SCI_CSN), 32'hFF);
        check({tag, "_ready_low"}, 32'(REQ_READY), 32'd0);
        step();
        check({tag, "_pulse_end"}, 32'(RESP_VALID), 32'd0);
        check({tag, "_ready_back"}, 32'(REQ_READY), 32'd1);
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESP_VALID) begin
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", 32'(RESP_ERR), 32'(e.err));
                check("resp_rdata", 32'(RESP_RDATA), 32'(e.rdata));
            end
        end
    end

    initial begin
        RSTN       = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_VALID6 = 1'b0;
        REQ_WNR    = 1'b0;
        REQ_SEL    = '0;
        REQ_ADDR   = '0;
        REQ_WDATA  = '0;
        SCI_RESP   = 1'b0;
        SCI_ACK    = 1'b0;

        // Reset values while asserted and on the first edge after release.
        repeat (2) step();
        check("rst_csn", 32'(SCI_CSN), 32'hFF);
        check("rst_req", 32'(SCI_REQ), 32'd0);
        check("rst_ready", 32'(REQ_READY), 32'd1);
        check("rst_valid", 32'(RESP_VALID), 32'd0);
        check("rst_rdata", 32'(RESP_RDATA), 32'd0);
        check("rst_err", 32'(RESP_ERR), 32'd0);
        RSTN = 1'b1;
        step();
        check("rel_csn", 32'(SCI_CSN), 32'hFF);
        check("rel_req", 32'(SCI_REQ), 32'd0);
        check("rel_ready", 32'(REQ_READY), 32'd1);
        check("rel_valid", 32'(RESP_VALID), 32'd0);

        // Write sel=2 addr=0x5 data=0xA3; stray ACK during the frame is ignored.
        issue(1'b1, 3'd2, 4'h5, 8'hA3, 1'b0, 8'h00);
        SCI_ACK = 1'b1;
        check("w1_cmd_csn", 32'(SCI_CSN), 32'hFB);
        expect_frame(8'hFB, 16'b0001_0101_1010_0011, 13);
        SCI_ACK = 1'b0;
        repeat (3) step();
        check("w1_waiting", 32'(RESP_VALID), 32'd0);
        SCI_ACK = 1'b1;
        step();
        SCI_ACK = 1'b0;
        expect_done("w1");

        // Read sel=0 addr=0x8 returning 0x7F with a two-cycle ACK gap after bit 3.
        issue(1'b0, 3'd0, 4'h8, 8'h00, 1'b0, 8'h7F);
        expect_frame(8'hFE, frame_bits(1'b0, 4'h8, 8'h00), 5);
        send_read(8'h7F, 4, 2);
        expect_done("r1");
        check("r1_rdata_hold", 32'(RESP_RDATA), 32'h7F);

        // Read to a silent slave: error response 64 cycles after entering WAIT_ACK.
        issue(1'b0, 3'd3, 4'h1, 8'h00, 1'b1, 8'h00);
        expect_frame(8'hF7, frame_bits(1'b0, 4'h1, 8'h00), 5);
        repeat (63) step();
        check("to_early", 32'(RESP_VALID), 32'd0);
        step();
        expect_done("to");

        // Out-of-range index on the six-slave instance: immediate error, no CSN.
        REQ_WNR    = 1'b1;
        REQ_SEL    = 3'd7;
        REQ_ADDR   = 4'h2;
        REQ_WDATA  = 8'h11;
        REQ_VALID6 = 1'b1;
        check("inv_ready", 32'(REQ_READY6), 32'd1);
        step();
        REQ_VALID6 = 1'b0;
        check("inv_valid", 32'(RESP_VALID6), 32'd1);
        check("inv_err", 32'(RESP_ERR6), 32'd1);
        check("inv_rdata", 32'(RESP_RDATA6), 32'd0);
        check("inv_csn", 32'(SCI_CSN6), 32'h3F);
        check("inv_req", 32'(SCI_REQ6), 32'd0);
        step();
        check("inv_pulse_end", 32'(RESP_VALID6), 32'd0);
        check("inv_ready_back", 32'(REQ_READY6), 32'd1);
        check("inv_csn_after", 32'(SCI_CSN6), 32'h3F);

        // Second request held during an active write waits for REQ_READY.
        issue(1'b1, 3'd5, 4'hC, 8'h3C, 1'b0, 8'h00);
        REQ_WNR   = 1'b0;
        REQ_SEL   = 3'd1;
        REQ_ADDR  = 4'h2;
        REQ_WDATA = 8'hFF;
        REQ_VALID = 1'b1;
        expect_frame(8'hDF, frame_bits(1'b1, 4'hC, 8'h3C), 13);
        step();
        SCI_ACK = 1'b1;
        step();
        SCI_ACK = 1'b0;
        check("held_w_valid", 32'(RESP_VALID), 32'd1);
        check("held_w_ready", 32'(REQ_READY), 32'd0);
        step();
        check("held_ready_up", 32'(REQ_READY), 32'd1);
        begin
            exp_t e;
            e.err   = 1'b0;
            e.rdata = 8'h96;
            sb.push_back(e);
        end
        step();
        REQ_VALID = 1'b0;
        expect_frame(8'hFD, frame_bits(1'b0, 4'h2, 8'h00), 5);
        send_read(8'h96, 8, 0);
        expect_done("held_r");

        // Reset during the address bits of a write aborts it without a response.
        issue(1'b1, 3'd4, 4'h9, 8'h55, 1'b0, 8'h00);
        void'(sb.pop_back());
        check("abort_csn_active", 32'(SCI_CSN), 32'hEF);
        repeat (2) step();
        RSTN = 1'b0;
        step();
        check("abort_csn", 32'(SCI_CSN), 32'hFF);
        check("abort_req", 32'(SCI_REQ), 32'd0);
        check("abort_ready", 32'(REQ_READY), 32'd1);
        check("abort_valid", 32'(RESP_VALID), 32'd0);
        RSTN = 1'b1;
        step();
        check("abort_rel_csn", 32'(SCI_CSN), 32'hFF);
        check("abort_rel_valid", 32'(RESP_VALID), 32'd0);

        // A following read completes normally.
        issue(1'b0, 3'd6, 4'h3, 8'h00, 1'b0, 8'hC5);
        expect_frame(8'hBF, frame_bits(1'b0, 4'h3, 8'h00), 5);
        send_read(8'hC5, 8, 0);
        expect_done("post_rst");

        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
